fetch_unit: RTL and testbench

- Instruction fetch stage. Sits directly upstream of the word-addressed, combinational-read instruction memory.
- Generates the byte PC and drives it as the memory address. Captures the returned instruction word with its PC into a small prefetch FIFO.
- Presents PC/instruction pairs to decode over a valid/ready handshake.
- Handles branch/jump redirects (FIFO flush) and front-end stalls.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a word-addressed,
// combinational-read instruction memory.
//
// pc_q drives the memory address directly. The returned word and its PC are
// pushed into a small prefetch FIFO, and decode drains the FIFO head over a
// valid/ready handshake. A redirect flushes the FIFO and reloads the PC.
// A stall suppresses new fetches, but the FIFO keeps draining.
//
// Optional build macro: FETCH_PERF_CNT_EN adds 32-bit fetch and redirect
// event counters (perf_fetch_cnt_o, perf_redirect_cnt_o).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   imem_addr_o         byte address to imem (== pc_q)
//   imem_instr_i        instruction word for imem_addr_o
//   redirect_i          taken branch/jump from execute
//   redirect_pc_i       redirect target (low 2 bits ignored)
//   stall_i             front-end hold, no new fetch
//   if_valid_o          FIFO head valid
//   if_ready_i          decode accepts head
//   if_instr_o          head instruction (NOP when empty)
//   if_pc_o             head PC (0 when empty)
//   occupancy_o         entries held
module fetch_unit #(
  parameter int                      DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]   RESET_PC   = 32'h0000_0000,
  parameter int                      FIFO_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic [DATA_WIDTH-1:0]             imem_addr_o,
  input  logic [DATA_WIDTH-1:0]             imem_instr_i,
  input  logic                              redirect_i,
  input  logic [DATA_WIDTH-1:0]             redirect_pc_i,
  input  logic                              stall_i,
  output logic                              if_valid_o,
  input  logic                              if_ready_i,
  output logic [DATA_WIDTH-1:0]             if_instr_o,
  output logic [DATA_WIDTH-1:0]             if_pc_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_fetch_cnt_o,
  output logic [31:0]                       perf_redirect_cnt_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [DATA_WIDTH-1:0]       pc_q;
  logic [CW-1:0]               cnt_q;
  logic [PW-1:0]               rptr_q, wptr_q;
  entry_t [FIFO_DEPTH-1:0]     fifo_q;

  logic push, pop;

  assign imem_addr_o = pc_q;
  assign if_valid_o  = (cnt_q != '0);
  assign occupancy_o = cnt_q;
  assign pop         = if_valid_o & if_ready_i;
  // A same-cycle pop frees a slot, so a full FIFO still accepts a fetch.
  assign push        = !redirect_i && !stall_i &&
                       ((cnt_q < CW'(FIFO_DEPTH)) || pop);

  // Head comes only from registered storage. When empty, it presents a
  // fixed NOP/0 pair instead of whatever stale data the slot holds.
  assign if_instr_o = if_valid_o ? fifo_q[rptr_q].instr : NOP;
  assign if_pc_o    = if_valid_o ? fifo_q[rptr_q].pc    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      cnt_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
    end else if (redirect_i) begin
      // The flush takes priority over the pop, so the head is dropped, not consumed.
      pc_q   <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      cnt_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      if (push) begin
        pc_q   <= pc_q + DATA_WIDTH'(4);
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the count alone qualifies every slot.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= '{pc: pc_q, instr: imem_instr_i};
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt_o    <= '0;
      perf_redirect_cnt_o <= '0;
    end else begin
      if (push)       perf_fetch_cnt_o    <= perf_fetch_cnt_o + 32'd1;
      if (redirect_i) perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 0, rst_n = 0;
  logic [31:0] imem_addr, imem_instr, redirect_pc = 0, if_instr, if_pc;
  logic        redirect = 0, stall = 0, if_valid, if_ready = 0;
  logic [1:0]  occupancy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_redir;
  int unsigned m_fetch = 0, m_redir = 0;
`endif

  logic [31:0] mem [64];
  assign imem_instr = mem[imem_addr[7:2]];

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
    .if_valid_o(if_valid), .if_ready_i(if_ready), .if_instr_o(if_instr),
    .if_pc_o(if_pc), .occupancy_o(occupancy)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt_o(perf_fetch), .perf_redirect_cnt_o(perf_redir)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        exp_q[$];
  logic [31:0] mpc = RPC;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch stream as a queue of {pc, word} pairs. A fetch is
  // taken whenever the queue has room after this cycle's hand-off.
  initial forever begin
    @(posedge clk);
    if (rst_n) begin
      if (redirect) begin
        exp_q.delete();
        mpc = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_PERF_CNT_EN
        m_redir++;
`endif
      end else if (!stall && exp_q.size() < DEPTH) begin
        exp_q.push_back('{pc: mpc, instr: mem[mpc[7:2]]});
        mpc = mpc + 32'd4;
`ifdef FETCH_PERF_CNT_EN
        m_fetch++;
`endif
      end
    end
  end

  // Monitor: compares the presented head against the scoreboard front.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("valid", {31'b0, if_valid}, {31'b0, exp_q.size() > 0});
      chk("occupancy", {30'b0, occupancy}, exp_q.size());
      chk("imem_addr", imem_addr, mpc);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch", perf_fetch, m_fetch);
      chk("perf_redirect", perf_redir, m_redir);
`endif
      if (if_valid && exp_q.size() > 0) begin
        chk("head_pc", if_pc, exp_q[0].pc);
        chk("head_instr", if_instr, exp_q[0].instr);
        if (if_ready) void'(exp_q.pop_front());
      end else if (!if_valid) begin
        chk("empty_instr", if_instr, 32'h13);
        chk("empty_pc", if_pc, 32'h0);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // Assert reset mid-cycle, check the immediate effect, release off-edge.
  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 0;
    exp_q.delete();
    mpc = RPC;
`ifdef FETCH_PERF_CNT_EN
    m_fetch = 0; m_redir = 0;
`endif
    #1;
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_occ", {30'b0, occupancy}, 32'h0);
    chk("rst_instr", if_instr, 32'h13);
    @(negedge clk); #2;
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h00100093; mem[1] = 32'h00200113; mem[2] = 32'h002081b3;

    // Sequential fetch
    do_reset();
    if_ready = 1;
    step(); chk("seq_pc0", if_pc, 32'h0); chk("seq_in0", if_instr, 32'h00100093);
    step(); chk("seq_pc1", if_pc, 32'h4); chk("seq_in1", if_instr, 32'h00200113);
    step(); chk("seq_pc2", if_pc, 32'h8); chk("seq_in2", if_instr, 32'h002081b3);

    // Backpressure
    do_reset();
    if_ready = 0;
    step(5);
    chk("bp_occ", {30'b0, occupancy}, 32'd2);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_head", if_pc, 32'h0);
    if_ready = 1;
    step(); chk("bp_pc1", if_pc, 32'h4);
    step(); chk("bp_pc2", if_pc, 32'h8);

    // Redirect while full
    do_reset();
    if_ready = 0;
    step(3);
    redirect = 1; redirect_pc = 32'h1C;
    step(); redirect = 0;
    chk("rd_valid", {31'b0, if_valid}, 32'h0);
    chk("rd_occ", {30'b0, occupancy}, 32'h0);
    chk("rd_addr", imem_addr, 32'h1C);
    step();
    chk("rd_pc", if_pc, 32'h1C);
    chk("rd_instr", if_instr, mem[7]);

    // Misaligned target with stall
    if_ready = 1;
    redirect = 1; stall = 1; redirect_pc = 32'h22;
    step(); redirect = 0;
    chk("ms_addr", imem_addr, 32'h20);
    step();
    chk("ms_hold_valid", {31'b0, if_valid}, 32'h0);
    chk("ms_hold_addr", imem_addr, 32'h20);
    stall = 0;
    step();
    chk("ms_pc", if_pc, 32'h20);

    // Async reset with a full FIFO
    if_ready = 0;
    step(3);
    chk("ar_occ", {30'b0, occupancy}, 32'd2);
    do_reset();
    if_ready = 1;
    step();
    chk("ar_restart", if_pc, RPC);

    // PC wrap past the top of the address space
    redirect = 1; redirect_pc = 32'hFFFF_FFF8;
    step(); redirect = 0;
    step(2);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_head", if_pc, 32'hFFFF_FFFC);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if_ready    = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 4) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      if (c == 700) do_reset();
      step();
    end

    redirect = 0; stall = 0; if_ready = 1;
    step(4);
    chk("drain_occ", {30'b0, occupancy}, exp_q.size());
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
